// File: rtl/trig_pkg.sv
// ---------------------------------------------------------------------------
// trig_pkg
// Shared definitions for the self-trigger arbiter:
//   - state_t   : arbiter FSM encoding (IDLE/REQ/BUSY/DEAD)
//   - LOST_MAX  : saturation value of the lost-trigger counter
//   - chan_bits : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam logic [15:0] LOST_MAX = 16'hFFFF;

    // ceil(log2(n)) with a floor of 1, valid for 2..32 channels
    function automatic int chan_bits(input int n);
        int b;
        b = 32'sd1;
        for (int i = 0; i < 5; i++) begin
            if ((32'sd1 << b) < n) begin
                b = b + 32'sd1;
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Finds the first set bit of 'pending'
// strictly after index 'last', scanning upward and wrapping at NCH-1.
// Ports:
//   pending [NCH]    : request vector
//   last    [CHBITS] : most recently granted channel
//   next    [CHBITS] : selected channel (0 when none)
//   valid            : at least one pending bit was found
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NCH    = 4,
    parameter int CHBITS = 2
) (
    input  logic [NCH-1:0]    pending,
    input  logic [CHBITS-1:0] last,
    output logic [CHBITS-1:0] next,
    output logic              valid
);

    // idx_s needs one extra bit: last + offset reaches at most 2*NCH-1
    logic [CHBITS:0] idx_s;

    // scan offsets 1..NCH so 'last' itself is considered only after a full wrap
    always_comb begin
        next  = {CHBITS{1'b0}};
        valid = 1'b0;
        idx_s = {(CHBITS+1){1'b0}};
        for (int off = 1; off <= NCH; off++) begin
            idx_s = {1'b0, last} + (CHBITS+1)'(off);
            if (idx_s >= (CHBITS+1)'(NCH)) begin
                idx_s = idx_s - (CHBITS+1)'(NCH);
            end else begin
                idx_s = idx_s;
            end
            if (!valid && pending[idx_s[CHBITS-1:0]]) begin
                valid = 1'b1;
                next  = idx_s[CHBITS-1:0];
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/strig_arbiter.sv
// ---------------------------------------------------------------------------
// strig_arbiter
// Latches 1-clock self-trigger pulses from NCH channels and serialises them
// onto a single event-writer handshake with round-robin arbitration, a
// programmable dead time after each event and a writer watchdog.
// Ports:
//   adcclk            : clock, rising edge
//   rst_n             : asynchronous active-low reset
//   enable            : low blocks new grants and flushes pending triggers
//   trig     [NCH]    : self-trigger pulses
//   deadtime [DTBITS] : idle clocks after each event
//   timeout  [TOBITS] : BUSY watchdog limit, 0 disables
//   wr_req / wr_chan  : request and channel to the event writer
//   wr_ack / wr_done  : writer accept and finish strobes
//   inhibit  [NCH]    : per-channel inhibit back to the trigger units
//   lost     [16]     : saturating count of cycles with a re-trigger
//   tmo_err           : sticky watchdog-abort flag
// ---------------------------------------------------------------------------
module strig_arbiter
    import trig_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CHBITS = chan_bits(NCH),
    parameter int DTBITS = 8,
    parameter int TOBITS = 12
) (
    input  logic              adcclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NCH-1:0]    trig,
    input  logic [DTBITS-1:0] deadtime,
    input  logic [TOBITS-1:0] timeout,
    output logic              wr_req,
    output logic [CHBITS-1:0] wr_chan,
    input  logic              wr_ack,
    input  logic              wr_done,
    output logic [NCH-1:0]    inhibit,
    output logic [15:0]       lost,
    output logic              tmo_err
);

    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [NCH-1:0]    pending_r;
    logic [CHBITS-1:0] rr_r;
    logic [CHBITS-1:0] wr_chan_r;
    logic              wr_req_r;
    logic              tmo_err_r;
    logic [15:0]       lost_r;
    logic [DTBITS-1:0] dead_cnt_r;
    logic [TOBITS-1:0] wd_cnt_r;

    logic [CHBITS-1:0] pick_s;
    logic              pick_valid_s;
    logic              grant_s;
    logic [NCH-1:0]    grant_mask_s;
    logic              lost_hit_s;
    logic              active_s;

    rr_pick #(
        .NCH    (NCH),
        .CHBITS (CHBITS)
    ) u_rr_pick (
        .pending (pending_r),
        .last    (rr_r),
        .next    (pick_s),
        .valid   (pick_valid_s)
    );

    // grant decode and re-trigger detection; a trig coinciding with the
    // grant-clear of its own channel is a fresh trigger, not a lost one
    always_comb begin
        grant_s = (state_r == ST_IDLE) && enable && pick_valid_s;
        if (grant_s) begin
            grant_mask_s = ONE_HOT0 << pick_s;
        end else begin
            grant_mask_s = {NCH{1'b0}};
        end
        lost_hit_s = enable && (|(trig & pending_r & ~grant_mask_s));
        active_s   = (state_r == ST_REQ) || (state_r == ST_BUSY);
    end

    // pending latch: set beats grant-clear; disabled arbiter flushes everything
    always_ff @(posedge adcclk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NCH{1'b0}};
        end else if (!enable) begin
            pending_r <= {NCH{1'b0}};
        end else begin
            pending_r <= (pending_r & ~grant_mask_s) | trig;
        end
    end

    // lost counter: at most one increment per cycle, saturating
    always_ff @(posedge adcclk or negedge rst_n) begin
        if (!rst_n) begin
            lost_r <= 16'h0000;
        end else if (lost_hit_s && (lost_r != LOST_MAX)) begin
            lost_r <= lost_r + 16'h0001;
        end else begin
            lost_r <= lost_r;
        end
    end

    // arbiter FSM with registered request, channel, counters and error flag
    always_ff @(posedge adcclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_r       <= CHBITS'(NCH - 1);
            wr_chan_r  <= {CHBITS{1'b0}};
            wr_req_r   <= 1'b0;
            tmo_err_r  <= 1'b0;
            dead_cnt_r <= {DTBITS{1'b0}};
            wd_cnt_r   <= {TOBITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        wr_chan_r <= pick_s;
                        rr_r      <= pick_s;
                        wr_req_r  <= 1'b1;
                        state_r   <= ST_REQ;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // a done in the ack cycle is deliberately ignored
                    if (wr_ack) begin
                        wr_req_r <= 1'b0;
                        wd_cnt_r <= {TOBITS{1'b0}};
                        state_r  <= ST_BUSY;
                    end else begin
                        state_r  <= ST_REQ;
                    end
                end
                ST_BUSY: begin
                    if (wr_done) begin
                        dead_cnt_r <= deadtime;
                        state_r    <= ST_DEAD;
                    end else if ((timeout != {TOBITS{1'b0}}) &&
                                 (wd_cnt_r == (timeout - TOBITS'(1)))) begin
                        tmo_err_r  <= 1'b1;
                        dead_cnt_r <= deadtime;
                        state_r    <= ST_DEAD;
                    end else begin
                        wd_cnt_r   <= wd_cnt_r + TOBITS'(1);
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_r == {DTBITS{1'b0}}) begin
                        state_r    <= ST_IDLE;
                    end else begin
                        dead_cnt_r <= dead_cnt_r - DTBITS'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wr_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_req  = wr_req_r;
    assign wr_chan = wr_chan_r;
    assign lost    = lost_r;
    assign tmo_err = tmo_err_r;
    assign inhibit = pending_r | (active_s ? (ONE_HOT0 << wr_chan_r) : {NCH{1'b0}});

endmodule

// File: tb/tb_strig_arbiter.sv
// ---------------------------------------------------------------------------
// tb_strig_arbiter
// Directed self-checking bench for strig_arbiter (NCH=4). Inputs change and
// outputs are sampled 1 time unit after each rising edge; "cycle c" is the
// interval following the c-th edge of a test.
// ---------------------------------------------------------------------------
module tb_strig_arbiter;
    import trig_pkg::*;

    logic        adcclk   = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic [3:0]  trig     = 4'b0000;
    logic [7:0]  deadtime = 8'd0;
    logic [11:0] timeout  = 12'd0;
    logic        wr_ack   = 1'b0;
    logic        wr_done  = 1'b0;
    logic        wr_req;
    logic [1:0]  wr_chan;
    logic [3:0]  inhibit;
    logic [15:0] lost;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;

    always #5 adcclk = ~adcclk;

    strig_arbiter #(
        .NCH    (4),
        .CHBITS (2),
        .DTBITS (8),
        .TOBITS (12)
    ) dut (
        .adcclk   (adcclk),
        .rst_n    (rst_n),
        .enable   (enable),
        .trig     (trig),
        .deadtime (deadtime),
        .timeout  (timeout),
        .wr_req   (wr_req),
        .wr_chan  (wr_chan),
        .wr_ack   (wr_ack),
        .wr_done  (wr_done),
        .inhibit  (inhibit),
        .lost     (lost),
        .tmo_err  (tmo_err)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge adcclk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        trig    = 4'b0000;
        wr_ack  = 1'b0;
        wr_done = 1'b0;
        tick();
        tick();
        check_val("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        check_val("rst_req", 32'(wr_req), 0);
        check_val("rst_chan", 32'(wr_chan), 0);
        check_val("rst_inhibit", 32'(inhibit), 0);
        check_val("rst_lost", 32'(lost), 0);
        check_val("rst_tmo", 32'(tmo_err), 0);
        check_val("rst_rr", 32'(dut.rr_r), 3);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (wr_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_val({tag, "_req_seen"}, 32'(wr_req), 1);
    endtask

    // one full handshake: ack for one cycle, done on the first BUSY cycle
    task automatic serve();
        wr_ack = 1'b1;
        tick();
        wr_ack  = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [3:0] exp_inh;

        // ---------------- single trigger ----------------
        apply_reset();
        enable   = 1'b1;
        deadtime = 8'd3;
        timeout  = 12'd0;
        for (int c = 0; c <= 16; c++) begin
            trig    = (c == 0) ? 4'b0100 : 4'b0000;
            wr_ack  = (c == 4);
            wr_done = (c == 10);
            check_val($sformatf("single_req_c%0d", c), 32'(wr_req), 32'(c >= 2 && c <= 4));
            check_val($sformatf("single_inh2_c%0d", c), 32'(inhibit[2]), 32'(c >= 1 && c <= 10));
            if (c >= 2 && c <= 4) begin
                check_val($sformatf("single_chan_c%0d", c), 32'(wr_chan), 2);
            end
            if (c == 14) begin
                check_val("single_dead_c14", 32'(dut.state_r), 32'(ST_DEAD));
            end
            if (c == 15) begin
                check_val("single_idle_c15", 32'(dut.state_r), 32'(ST_IDLE));
            end
            tick();
        end
        wr_ack  = 1'b0;
        wr_done = 1'b0;
        check_val("single_lost", 32'(lost), 0);

        // ---------------- round robin ----------------
        apply_reset();
        enable   = 1'b1;
        deadtime = 8'd0;
        trig     = 4'b1111;
        tick();
        trig = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_req($sformatf("rr%0d", k));
            check_val($sformatf("rr_chan%0d", k), 32'(wr_chan), k);
            serve();
            exp_inh = 4'b1111 << (k + 1);
            check_val($sformatf("rr_inhibit%0d", k), 32'(inhibit), 32'(exp_inh));
        end
        check_val("rr_lost", 32'(lost), 0);

        // ---------------- lost counting / enable low ----------------
        apply_reset();
        enable   = 1'b1;
        deadtime = 8'd0;
        trig     = 4'b0011;
        tick();
        trig = 4'b0000;
        wait_req("lost");
        check_val("lost_chan", 32'(wr_chan), 0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check_val("lost_busy", 32'(dut.state_r), 32'(ST_BUSY));
        for (int i = 0; i < 3; i++) begin
            trig = 4'b0010;
            tick();
            trig = 4'b0000;
            tick();
        end
        check_val("lost_three", 32'(lost), 3);
        check_val("lost_inhibit", 32'(inhibit), 32'(4'b0011));
        enable = 1'b0;
        trig   = 4'b0110;
        tick();
        trig = 4'b0000;
        tick();
        check_val("dis_lost", 32'(lost), 3);
        check_val("dis_inhibit", 32'(inhibit), 32'(4'b0001));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("dis_no_req", 32'(wr_req), 0);
        check_val("dis_idle", 32'(dut.state_r), 32'(ST_IDLE));
        enable = 1'b1;

        // ---------------- watchdog ----------------
        apply_reset();
        enable   = 1'b1;
        deadtime = 8'd2;
        timeout  = 12'd16;
        trig     = 4'b1000;
        tick();
        trig = 4'b0000;
        wait_req("wd");
        check_val("wd_chan", 32'(wr_chan), 3);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("wd_busy%0d", i), 32'(dut.state_r), 32'(ST_BUSY));
            check_val($sformatf("wd_tmo0_%0d", i), 32'(tmo_err), 0);
            tick();
        end
        check_val("wd_dead", 32'(dut.state_r), 32'(ST_DEAD));
        check_val("wd_tmo1", 32'(tmo_err), 1);
        check_val("wd_inhibit", 32'(inhibit), 0);
        tick();
        tick();
        check_val("wd_dead_last", 32'(dut.state_r), 32'(ST_DEAD));
        tick();
        check_val("wd_idle", 32'(dut.state_r), 32'(ST_IDLE));
        check_val("wd_tmo_sticky", 32'(tmo_err), 1);
        timeout = 12'd0;
        trig    = 4'b0001;
        tick();
        trig = 4'b0000;
        wait_req("wd0");
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        check_val("wd0_still_busy", 32'(dut.state_r), 32'(ST_BUSY));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check_val("wd0_dead", 32'(dut.state_r), 32'(ST_DEAD));

        // ---------------- async reset mid-BUSY ----------------
        apply_reset();
        enable   = 1'b1;
        deadtime = 8'd0;
        timeout  = 12'd0;
        trig     = 4'b0011;
        tick();
        trig = 4'b0010;
        tick();
        trig = 4'b0000;
        wait_req("ar");
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check_val("ar_pre_lost", 32'(lost), 1);
        check_val("ar_pre_inhibit", 32'(inhibit), 32'(4'b0011));
        #3;
        rst_n = 1'b0;
        #1;
        check_val("ar_req", 32'(wr_req), 0);
        check_val("ar_inhibit", 32'(inhibit), 0);
        check_val("ar_lost", 32'(lost), 0);
        check_val("ar_state", 32'(dut.state_r), 32'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        trig = 4'b0100;
        tick();
        trig = 4'b0000;
        check_val("ar_post_c1_req", 32'(wr_req), 0);
        tick();
        check_val("ar_post_c2_req", 32'(wr_req), 1);
        check_val("ar_post_chan", 32'(wr_chan), 2);
        serve();

        // ---------------- simultaneous events ----------------
        apply_reset();
        enable   = 1'b1;
        deadtime = 8'd0;
        trig     = 4'b0001;
        tick();
        trig = 4'b0001;
        tick();
        trig = 4'b0000;
        check_val("sim_req", 32'(wr_req), 1);
        check_val("sim_chan", 32'(wr_chan), 0);
        check_val("sim_pending", 32'(dut.pending_r), 1);
        check_val("sim_lost", 32'(lost), 0);
        wr_ack  = 1'b1;
        wr_done = 1'b1;
        tick();
        wr_ack  = 1'b0;
        wr_done = 1'b0;
        check_val("sim_ackdone_busy", 32'(dut.state_r), 32'(ST_BUSY));
        tick();
        tick();
        check_val("sim_still_busy", 32'(dut.state_r), 32'(ST_BUSY));
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        wait_req("sim2");
        check_val("sim2_chan", 32'(wr_chan), 0);
        check_val("sim2_pending", 32'(dut.pending_r), 0);
        serve();
        check_val("sim_end_lost", 32'(lost), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strig_arbiter.md
Name: strig_arbiter

Overview:
- Collects the 1-clock self-trigger pulses from the per-channel self-trigger units (NCH channels) and serialises them into one shared event-writer interface using round-robin arbitration.
- Enforces a programmable dead time after each event and a watchdog timeout on the writer.
- Returns a per-channel inhibit that feeds the self-trigger units' inhibit inputs.
- Sits between the channel self-trigger units and the circular-buffer writing state machine, in the adcclk domain.

Parameters:
- NCH, 4: number of channels arbitrated (2..16).
- CHBITS, 2: width of the channel index; must equal ceil(log2(NCH)).
- DTBITS, 8: width of the dead-time counter.
- TOBITS, 12: width of the writer watchdog counter.

Ports:
- adcclk  in  1  ADC clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arbitration enable; low blocks new grants.
- trig  in  NCH  self-trigger pulses, 1 clk each, bit i = channel i.
- deadtime  in  DTBITS  idle clocks inserted after each completed or aborted event.
- timeout  in  TOBITS  maximum clocks in BUSY; 0 disables the watchdog.
- wr_req  out  1  event request to the writer.
- wr_chan  out  CHBITS  channel being served; valid while wr_req or BUSY.
- wr_ack  in  1  writer accepted the request.
- wr_done  in  1  writer finished the event (1 clk).
- inhibit  out  NCH  bit i high while channel i is pending or being served.
- lost  out  16  count of triggers that arrived on an already-pending channel; saturates at 16'hFFFF.
- tmo_err  out  1  sticky; set on a watchdog abort; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pending=0; rr pointer=NCH-1.
  - wr_req=0, wr_chan=0, inhibit=0, lost=0, tmo_err=0; dead/watchdog counters=0.
- Pending latch:
  - On trig[i]=1, pending[i] is set.
  - If pending[i] was already 1, lost increments by 1 (saturating).
  - Multiple trig bits in one cycle are each handled independently; lost can increase by at most 1 per cycle. The count is by cycle, not by bit.
  - If enable=0, pending is cleared each cycle, trig is ignored and lost is not incremented.
- State machine: IDLE, REQ, BUSY, DEAD.
  - IDLE:
    - If enable=1 and pending≠0, choose the first set pending bit strictly after the rr pointer, scanning upward with wrap-around.
    - Register it into wr_chan and the rr pointer, clear that pending bit, set wr_req=1, go to REQ.
    - The grant is registered: wr_req rises 1 clk after the cycle in which IDLE sees pending≠0. With a trig pulse on cycle t, wr_req is high from cycle t+2.
  - REQ: hold wr_req=1 and wr_chan stable until wr_ack=1. On ack, wr_req=0 and go to BUSY with watchdog=0. There is no timeout in REQ.
  - BUSY:
    - Watchdog increments each clk.
    - On wr_done=1, go to DEAD with counter=deadtime.
    - Otherwise, if timeout≠0 and watchdog reaches timeout-1, set tmo_err=1 and go to DEAD with counter=deadtime.
  - DEAD: decrement each clk; go to IDLE when the counter is 0 (deadtime=0 gives exactly 1 clk in DEAD).
- wr_ack and wr_done in the same cycle while in REQ are treated as ack only; done is ignored.
- Grant-clear vs new trig on the same channel and cycle: set wins, the channel stays pending, and lost is not incremented.
- inhibit[i] = pending[i] OR (state in {REQ,BUSY} AND wr_chan=i). It is combinational from registers.
- enable falling mid-transaction: the current REQ/BUSY/DEAD completes normally, and no new grant is made.
- Round-robin fairness: with all channels continuously pending, grants cycle 0,1,2,...,NCH-1,0.

Decomposition:
- Shared package (trig_pkg):
  - state encoding constants ST_IDLE=0, ST_REQ=1, ST_BUSY=2, ST_DEAD=3;
  - a function for the CHBITS width.
- One natural sub-module: rr_pick. It is combinational: pending vector plus last index in, next index and valid out.
- Pending, counters and the FSM stay in strig_arbiter.

Test Plan:
- Single trigger: enable=1, deadtime=3, trig=4'b0100 at cycle 0; ack at cycle 4, done at cycle 10.
  - wr_req high cycles 2-4, wr_chan=2.
  - inhibit[2] high cycles 1-10.
  - IDLE again at cycle 15.
  - lost=0.
- Round-robin: trig=4'b1111 once, writer acks and finishes immediately, deadtime=0. Grants in order 0,1,2,3, and every inhibit bit drops after its own event.
- Lost counting:
  - Channel 1 pending, BUSY on channel 0, trig[1] pulsed 3 more times → lost=3.
  - Trig during enable=0 → lost unchanged and pending cleared.
- Watchdog: timeout=16, ack given, no done. tmo_err=1 after 16 BUSY cycles, then DEAD then IDLE. With timeout=0, it waits indefinitely.
- Async reset mid-BUSY: pull rst_n low asynchronously (not clock-aligned). wr_req, inhibit and lost become 0 immediately; after release, a new trig is served normally.
- Simultaneous events:
  - trig[0] in the same cycle channel 0 is granted → channel 0 pending again and served next.
  - ack and done in the same cycle → state BUSY, done ignored.
